// File: rtl/dbi_burst_ctrl.sv
// dbi_burst_ctrl: byte FIFO feeding fixed-length bursts onto a 9-wire bus
// with optional data-bus inversion, plus a saturating bus toggle counter.
module dbi_burst_ctrl #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned BL    = 8,
  parameter int unsigned GAP   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_dbi,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic       stat_clr,
  output logic [8:0] bus_v,
  output logic       bus_valid,
  output logic       burst_done,
  output logic [15:0] trans_cnt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = (BL > 1) ? $clog2(BL) : 1;
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t          state;
  logic [BW-1:0]   beat;
  logic [GW-1:0]   gap_cnt;
  logic            dbi_l;

  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic            push;
  logic            pop;
  logic [7:0]      pop_byte;
  logic [8:0]      diff;
  logic            inv;
  logic [8:0]      enc;
  logic [3:0]      toggles;
  logic [16:0]     trans_sum;
  logic [15:0]     trans_next;

  // Number of set bits in a 9-bit word.
  function automatic logic [3:0] popcount9(input logic [8:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 9; i++) begin
      c = c + 4'(v[i]);
    end
    return c;
  endfunction

  // FIFO handshake: ready only depends on the registered occupancy.
  assign in_ready = (count < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (state == ST_SEND);
  assign pop_byte = mem[rd_ptr];

  // DBI encoder: invert when at least 5 of the 9 wires would otherwise toggle.
  always_comb begin
    diff       = {pop_byte, 1'b0} ^ bus_v;
    inv        = dbi_l && (popcount9(diff) >= 4'd5);
    enc        = {pop_byte ^ {8{inv}}, inv};
    toggles    = popcount9(enc ^ bus_v);
    trans_sum  = {1'b0, trans_cnt} + 17'(toggles);
    trans_next = trans_sum[16] ? 16'hFFFF : trans_sum[15:0];
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop nets out.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Burst sequencer: wait for a full burst, send BL beats, then idle GAP cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      beat       <= '0;
      gap_cnt    <= '0;
      dbi_l      <= 1'b0;
      bus_v      <= 9'h000;
      bus_valid  <= 1'b0;
      burst_done <= 1'b0;
    end else begin
      bus_valid  <= 1'b0;
      burst_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (count >= CW'(BL)) begin
            state <= ST_SEND;
            dbi_l <= en_dbi;
            beat  <= '0;
          end
        end
        ST_SEND: begin
          bus_v     <= enc;
          bus_valid <= 1'b1;
          if (beat == BW'(BL - 1)) begin
            burst_done <= 1'b1;
            state      <= ST_GAP;
            gap_cnt    <= '0;
            beat       <= '0;
          end else begin
            beat <= beat + BW'(1);
          end
        end
        ST_GAP: begin
          if (gap_cnt == GW'(GAP - 1)) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Bus toggle statistics; a clear takes priority over a coincident beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      trans_cnt <= 16'h0000;
    end else if (stat_clr) begin
      trans_cnt <= 16'h0000;
    end else if (state == ST_SEND) begin
      trans_cnt <= trans_next;
    end
  end

endmodule

// File: tb/tb_dbi_burst_ctrl.sv
// Bench for dbi_burst_ctrl: queue-based reference model checked every cycle,
// plus directed cases with hand-computed bus words.
module tb_dbi_burst_ctrl;

  localparam int DEPTH = 16;
  localparam int BL    = 8;
  localparam int GAP   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_dbi;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        stat_clr;
  logic [8:0]  bus_v;
  logic        bus_valid;
  logic        burst_done;
  logic [15:0] trans_cnt;

  dbi_burst_ctrl #(.DEPTH(DEPTH), .BL(BL), .GAP(GAP)) dut (
    .clk        (clk),
    .rst        (rst),
    .en_dbi     (en_dbi),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .stat_clr   (stat_clr),
    .bus_v      (bus_v),
    .bus_valid  (bus_valid),
    .burst_done (burst_done),
    .trans_cnt  (trans_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: bytes in a queue; a burst may begin once BL bytes are
  // held and the previous burst's gap has elapsed.
  logic [7:0] q[$];
  int         m_edge    = 0;
  bit         m_sending = 1'b0;
  int         m_beats   = 0;
  int         m_next_ok = 0;
  bit         m_dbi     = 1'b0;
  logic [8:0] m_bus     = 9'h000;
  bit         m_valid   = 1'b0;
  bit         m_done    = 1'b0;
  int         m_trans   = 0;
  int         m_sz;
  int         m_ham;
  logic [7:0] m_u;
  logic [8:0] m_w;

  always @(posedge clk) begin
    m_edge++;
    if (rst) begin
      q.delete();
      m_sending = 1'b0;
      m_beats   = 0;
      m_next_ok = 0;
      m_dbi     = 1'b0;
      m_bus     = 9'h000;
      m_valid   = 1'b0;
      m_done    = 1'b0;
      m_trans   = 0;
    end else begin
      m_sz    = q.size();
      m_valid = 1'b0;
      m_done  = 1'b0;
      if (m_sending) begin
        m_u   = q.pop_front();
        m_ham = $countones({m_u, 1'b0} ^ m_bus);
        m_w   = (m_dbi && m_ham >= 5) ? {~m_u, 1'b1} : {m_u, 1'b0};
        m_trans = m_trans + $countones(m_w ^ m_bus);
        if (m_trans > 65535) m_trans = 65535;
        m_bus   = m_w;
        m_valid = 1'b1;
        m_beats++;
        if (m_beats == BL) begin
          m_done    = 1'b1;
          m_sending = 1'b0;
          m_next_ok = m_edge + GAP + 1;
        end
      end else if (m_edge >= m_next_ok && m_sz >= BL) begin
        m_sending = 1'b1;
        m_beats   = 0;
        m_dbi     = en_dbi;
      end
      if (in_valid && m_sz < DEPTH) q.push_back(in_data);
      if (stat_clr) m_trans = 0;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("bus_v", 32'(bus_v), 32'(m_bus));
      chk("bus_valid", 32'(bus_valid), 32'(m_valid));
      chk("burst_done", 32'(burst_done), 32'(m_done));
      chk("trans_cnt", 32'(trans_cnt), 32'(m_trans));
      chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    end
  end

  task automatic directed(input bit en, input logic [7:0] b, input logic [8:0] exp_w,
                          input logic [15:0] exp_t, input string nm);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk({nm, "_ready_after_rst"}, 32'(in_ready), 32'd1);
    en_dbi   = en;
    in_valid = 1'b1;
    in_data  = b;
    repeat (BL) step();
    in_valid = 1'b0;
    chk({nm, "_lat0"}, 32'(bus_valid), 32'd0);
    step();
    chk({nm, "_lat1"}, 32'(bus_valid), 32'd0);
    step();
    for (int i = 0; i < BL; i++) begin
      chk({nm, "_valid"}, 32'(bus_valid), 32'd1);
      chk({nm, "_word"}, 32'(bus_v), 32'(exp_w));
      chk({nm, "_model_word"}, 32'(m_bus), 32'(exp_w));
      chk({nm, "_done"}, 32'(burst_done), 32'(i == BL - 1));
      step();
    end
    chk({nm, "_idle"}, 32'(bus_valid), 32'd0);
    chk({nm, "_hold"}, 32'(bus_v), 32'(exp_w));
    chk({nm, "_trans"}, 32'(trans_cnt), 32'(exp_t));
    chk({nm, "_model_trans"}, 32'(m_trans), 32'(exp_t));
  endtask

  task automatic wait_valid(input int lim, input string nm);
    int k;
    k = 0;
    while (!bus_valid && k < lim) begin
      step();
      k++;
    end
    if (!bus_valid) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  bit seen_full;
  bit acc;
  int p;
  int k;

  initial begin
    rst      = 1'b1;
    en_dbi   = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    stat_clr = 1'b0;
    repeat (2) step();
    chk_en = 1'b1;
    chk("rst_bus_v", 32'(bus_v), 32'h000);
    chk("rst_valid", 32'(bus_valid), 32'd0);
    chk("rst_done", 32'(burst_done), 32'd0);
    chk("rst_trans", 32'(trans_cnt), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    directed(1'b1, 8'h00, 9'h000, 16'd0, "zeros_dbi");
    directed(1'b1, 8'hFF, 9'h001, 16'd1, "ones_dbi");
    directed(1'b0, 8'hFF, 9'h1FE, 16'd8, "ones_nodbi");

    // Producer outruns the drain: FIFO must fill and deassert ready.
    rst = 1'b1;
    step();
    rst = 1'b0;
    en_dbi    = 1'b1;
    in_valid  = 1'b1;
    seen_full = 1'b0;
    for (int i = 0; i < 200 && !seen_full; i++) begin
      in_data = 8'($urandom);
      step();
      if (!in_ready) seen_full = 1'b1;
    end
    chk("fifo_full_seen", 32'(seen_full), 32'd1);
    in_valid = 1'b0;
    repeat (60) step();
    chk("fifo_drained_idle", 32'(bus_valid), 32'd0);

    // Reset in the middle of a burst.
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < BL; i++) begin
      in_data = 8'($urandom);
      step();
    end
    in_valid = 1'b0;
    wait_valid(10, "midrst");
    repeat (3) step();
    chk("midrst_beat4", 32'(bus_valid), 32'd1);
    rst = 1'b1;
    step();
    chk("midrst_valid", 32'(bus_valid), 32'd0);
    chk("midrst_bus", 32'(bus_v), 32'h000);
    chk("midrst_done", 32'(burst_done), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    repeat (12) step();
    chk("midrst_no_burst", 32'(bus_valid), 32'd0);

    // Randomized traffic with varying producer density.
    p = 2;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) p = $urandom_range(0, 4);
      in_valid = ($urandom_range(0, 3) < p);
      in_data  = 8'($urandom);
      if ($urandom_range(0, 15) == 0) en_dbi = $urandom_range(0, 1);
      stat_clr = ($urandom_range(0, 63) == 0);
      rst      = ($urandom_range(0, 999) == 0);
      step();
    end
    rst      = 1'b0;
    stat_clr = 1'b0;

    // Saturation: alternating AA/55 without DBI toggles 8 wires per beat.
    rst = 1'b1;
    step();
    rst = 1'b0;
    en_dbi   = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hAA;
    k = 0;
    while (trans_cnt != 16'hFFFF && k < 20000) begin
      acc = in_ready;
      step();
      if (acc) in_data = ~in_data;
      k++;
    end
    chk("sat_reached", 32'(trans_cnt), 32'hFFFF);
    for (int i = 0; i < 30; i++) begin
      acc = in_ready;
      step();
      if (acc) in_data = ~in_data;
    end
    chk("sat_hold", 32'(trans_cnt), 32'hFFFF);
    k = 0;
    while (!(bus_valid && !burst_done) && k < 40) begin
      acc = in_ready;
      step();
      if (acc) in_data = ~in_data;
      k++;
    end
    chk("clr_in_burst", 32'(bus_valid && !burst_done), 32'd1);
    stat_clr = 1'b1;
    acc = in_ready;
    step();
    if (acc) in_data = ~in_data;
    stat_clr = 1'b0;
    chk("clr_on_beat_valid", 32'(bus_valid), 32'd1);
    chk("clr_on_beat", 32'(trans_cnt), 32'd0);
    in_valid = 1'b0;
    repeat (40) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dbi_burst_ctrl.md
DBI_BURST_CTRL -- requirements
Module: dbi_burst_ctrl

Interface
REQ-001 Parameter DEPTH, default 16: byte FIFO depth, power of two, DEPTH >= BL.
REQ-002 Parameter BL, default 8: beats per burst.
REQ-003 Parameter GAP, default 2: idle cycles after each burst, minimum 1.
REQ-004 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-005 Port rst  input  1: synchronous, active-high reset.
REQ-006 Port en_dbi  input  1: DBI enable; sampled at burst start.
REQ-007 Port in_valid  input  1: producer byte valid.
REQ-008 Port in_data  input  8: producer byte.
REQ-009 Port in_ready  output  1: FIFO can accept a byte.
REQ-010 Port stat_clr  input  1: clears the transition counter.
REQ-011 Port bus_v  output  9: encoded bus word; [8:1] is the payload and [0] is the invert flag.
REQ-012 Port bus_valid  output  1: bus_v carries a burst beat.
REQ-013 Port burst_done  output  1: single-cycle pulse on the last beat.
REQ-014 Port trans_cnt  output  16: saturating count of bus_v bit transitions.

Function
REQ-015 The FIFO SHALL accept a byte when in_valid && in_ready, with in_ready = (count < DEPTH), combinational from registered count.
REQ-016 The FIFO SHALL net simultaneous push and pop to an unchanged count; wrap-around SHALL follow DEPTH-modulo pointers.
REQ-017 The FSM SHALL have states IDLE, SEND and GAP.
REQ-018 IDLE SHALL go to SEND when registered count >= BL; en_dbi SHALL be latched into dbi_l on that transition.
REQ-019 SEND SHALL pop one byte per cycle for exactly BL cycles, tracked by a beat counter 0..BL-1, then go to GAP.
REQ-020 GAP SHALL last GAP cycles, then return to IDLE; a new burst SHALL start no earlier than the cycle after GAP ends.
REQ-021 Per popped byte u, the encoder SHALL compute d = {u,1'b0} XOR bus_v and set t = dbi_l && (popcount(d) >= 5), which is the 9-bit majority.
REQ-022 The encoded word SHALL be {u XOR {8{t}}, t}, registered into bus_v at the edge ending that SEND cycle, with bus_valid <= 1.
REQ-023 Latency: byte BL accepted at edge k -> state SEND after edge k+1 -> first beat visible after edge k+2.
REQ-024 burst_done SHALL be 1 in the same cycle bus_v shows beat BL-1, and 0 otherwise.
REQ-025 Outside SEND beats, bus_valid SHALL be 0 and bus_v SHALL hold its last value, producing no idle toggles.
REQ-026 On each beat, trans_cnt SHALL add popcount(new bus_v XOR old bus_v), saturating at 16'hFFFF.
REQ-027 stat_clr SHALL zero trans_cnt; if stat_clr coincides with a beat, the clear SHALL win.
REQ-028 Pushes SHALL continue during SEND and GAP.
REQ-029 A change of en_dbi mid-burst SHALL have no effect until the next burst start.

Reset
REQ-030 On rst=1 at an edge: state=IDLE, FIFO empty (count=0, pointers 0), beat counter=0, dbi_l=0.
REQ-031 On rst=1 at an edge: bus_v=9'h000, bus_valid=0, burst_done=0, trans_cnt=0.
REQ-032 Reset during SEND or GAP SHALL abort the burst and discard FIFO contents.
REQ-033 in_ready SHALL be 1 in the cycle after reset deasserts.

Verification
REQ-034 Reset, en_dbi=1, push 8x 8'h00 -> 8 beats bus_v=9'h000, burst_done on beat 8, trans_cnt=0; first beat 2 cycles after the 8th accept.
REQ-035 Reset, en_dbi=1, push 8x 8'hFF -> beat 1 bus_v=9'h001 (d has 8 ones, t=1); beats 2-8 bus_v=9'h001; trans_cnt=1.
REQ-036 Reset, en_dbi=0, push 8x 8'hFF -> all beats bus_v=9'h1FE; trans_cnt=8.
REQ-037 Hold in_valid=1 with no burst drain possible -> exactly DEPTH=16 bytes accepted and in_ready=0 at count 16; during SEND, a push and pop in the same cycle keep count constant; pointers wrap correctly over 3 bursts.
REQ-038 Assert rst at beat 4 of a burst -> next cycle bus_valid=0, bus_v=9'h000, count=0, no burst_done.
REQ-039 Preload trans_cnt near 16'hFFFF with alternating 8'hAA/8'h55 bursts (en_dbi=0) -> trans_cnt saturates at 16'hFFFF; stat_clr during a beat -> 0.
